// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator.
//   - SRC_* : encoding of src_o, i.e. which selection produced the current addr_o.
//   - DEF_* : default parameter values used by pc_gen.
//   - clog2 : index width needed to address 'value' items, never less than 1.
package pc_pkg;

    localparam logic [2:0] SRC_RESET = 3'd0;
    localparam logic [2:0] SRC_SEQ   = 3'd1;
    localparam logic [2:0] SRC_EXC   = 3'd2;
    localparam logic [2:0] SRC_REDIR = 3'd3;
    localparam logic [2:0] SRC_PEND  = 3'd4;
    localparam logic [2:0] SRC_RAS   = 3'd5;

    localparam int DEF_PC_W        = 32;
    localparam int DEF_START_VALUE = 0;
    localparam int DEF_EXC_VECTOR  = 'h80;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk_i, reset_i   : clock, asynchronous active-low reset
//   push_i           : push push_addr_i (when full, the oldest entry is overwritten)
//   push_addr_i      : return address to push
//   pop_i            : pop the top entry; on an empty stack only underflow_o pulses
//   top_o            : current top entry (valid when !empty_o)
//   empty_o, full_o  : count == 0 / count == DEPTH
//   underflow_o      : registered 1-cycle pulse after a pop on an empty stack
// Callers only assert push_i/pop_i on cycles the stack is allowed to change.
module pc_ras
    import pc_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_addr_i,
    input  logic            pop_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            underflow_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_inc;
    logic [CNT_W-1:0] count_q;
    logic             underflow_q;

    // DEPTH is a power of two, so the pointer wraps on its own; when full,
    // top+1 is exactly the oldest slot and gets overwritten.
    assign top_inc     = top_q + 1'b1;
    assign top_o       = mem_q[top_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign underflow_o = underflow_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            top_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            underflow_q <= pop_i & empty_o;
            if (pop_i && !empty_o) begin
                // Push+pop together: the caller consumes the old top and the
                // push replaces it in place, so depth is unchanged.
                if (push_i) begin
                    mem_q[top_q] <= push_addr_i;
                end else begin
                    top_q   <= top_q - 1'b1;
                    count_q <= count_q - 1'b1;
                end
            end else if (push_i) begin
                mem_q[top_inc] <= push_addr_i;
                top_q          <= top_inc;
                if (!full_o) count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator at the head of IF.
//   clk_i, reset_i   : clock, asynchronous active-low reset
//   enable_i         : 0 freezes all state and ignores every request
//   stall_i          : PC and RAS hold; redirects are captured as pending
//   exc_i            : load EXC_VECTOR (even while stalled), drop pending
//   redir_valid_i    : per-channel redirect request, channel 0 highest priority
//   redir_addr_i     : channel k target at [k*PC_W +: PC_W]
//   ras_push_i/_addr : call, push return address
//   ras_pop_i        : return, fetch from RAS top
//   addr_o, src_o    : current fetch PC and what produced it
//   pending_o        : a redirect is held awaiting stall release
//   ras_empty_o, ras_full_o, ras_underflow_o : RAS status
// Handshake: redirect channels are valid-only; a request is sampled on any
// enabled edge and is never back-pressured. During a stall it is captured
// into the pending register, otherwise it takes effect at the next edge.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter logic [PC_W-1:0] START_VALUE = PC_W'(DEF_START_VALUE),
    parameter int              STEP        = 4,
    parameter int              N_REDIR     = 2,
    parameter int              RAS_DEPTH   = 8,
    parameter logic [PC_W-1:0] EXC_VECTOR  = PC_W'(DEF_EXC_VECTOR)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    stall_i,
    input  logic                    exc_i,
    input  logic [N_REDIR-1:0]      redir_valid_i,
    input  logic [N_REDIR*PC_W-1:0] redir_addr_i,
    input  logic                    ras_push_i,
    input  logic [PC_W-1:0]         ras_push_addr_i,
    input  logic                    ras_pop_i,
    output logic [PC_W-1:0]         addr_o,
    output logic [2:0]              src_o,
    output logic                    pending_o,
    output logic                    ras_empty_o,
    output logic                    ras_full_o,
    output logic                    ras_underflow_o
);

    localparam int              IDX_W      = clog2(N_REDIR);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(STEP) - 1'b1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [2:0]       src_q, src_d;
    logic             pend_q, pend_d;
    logic [PC_W-1:0]  pend_addr_q, pend_addr_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

    logic             live_valid;
    logic [IDX_W-1:0] live_idx;
    logic [PC_W-1:0]  live_addr;
    logic             live_wins;

    logic             ras_push_en, ras_pop_en;
    logic [PC_W-1:0]  ras_top;
    logic             ras_empty;

    // Highest-priority live channel: scan downwards so the lowest index wins.
    always_comb begin
        live_valid = 1'b0;
        live_idx   = '0;
        live_addr  = '0;
        for (int k = N_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                live_valid = 1'b1;
                live_idx   = IDX_W'(k);
                live_addr  = redir_addr_i[k*PC_W +: PC_W] & ALIGN_MASK;
            end
        end
    end

    // A live redirect beats a held one when its priority is equal or higher;
    // the same test decides whether it overwrites pending during a stall.
    assign live_wins = live_valid && (!pend_q || (live_idx <= pend_idx_q));

    always_comb begin
        pc_d        = pc_q;
        src_d       = src_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_idx_d  = pend_idx_q;
        ras_push_en = 1'b0;
        ras_pop_en  = 1'b0;
        if (enable_i) begin
            if (exc_i) begin
                pc_d   = EXC_VECTOR;
                src_d  = SRC_EXC;
                pend_d = 1'b0;
            end else if (stall_i) begin
                if (live_wins) begin
                    pend_d      = 1'b1;
                    pend_addr_d = live_addr;
                    pend_idx_d  = live_idx;
                end
            end else begin
                pend_d = 1'b0;
                if (live_wins) begin
                    pc_d  = live_addr;
                    src_d = SRC_REDIR;
                end else if (pend_q) begin
                    pc_d  = pend_addr_q;
                    src_d = SRC_PEND;
                end else begin
                    // RAS only moves when nothing of higher priority redirected.
                    ras_push_en = ras_push_i;
                    ras_pop_en  = ras_pop_i;
                    if (ras_pop_i && !ras_empty) begin
                        pc_d  = ras_top;
                        src_d = SRC_RAS;
                    end else begin
                        pc_d  = pc_q + PC_W'(STEP);
                        src_d = SRC_SEQ;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q        <= START_VALUE;
            src_q       <= SRC_RESET;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_idx_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            src_q       <= src_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_idx_q  <= pend_idx_d;
        end
    end

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (ras_push_en),
        .push_addr_i (ras_push_addr_i),
        .pop_i       (ras_pop_en),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full_o),
        .underflow_o (ras_underflow_o)
    );

    assign addr_o      = pc_q;
    assign src_o       = src_q;
    assign pending_o   = pend_q;
    assign ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    import pc_pkg::*;

    localparam int              PC_W        = 32;
    localparam int              STEP        = 4;
    localparam int              N_REDIR     = 2;
    localparam int              RAS_DEPTH   = 8;
    localparam logic [PC_W-1:0] START_VALUE = 32'h0;
    localparam logic [PC_W-1:0] EXC_VECTOR  = 32'h80;
    localparam int              EXP_W       = PC_W + 7;

    // ---------------- clock / reset ----------------
    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                    enable_i        = 1'b0;
    logic                    stall_i         = 1'b0;
    logic                    exc_i           = 1'b0;
    logic [N_REDIR-1:0]      redir_valid_i   = '0;
    logic [N_REDIR*PC_W-1:0] redir_addr_i    = '0;
    logic                    ras_push_i      = 1'b0;
    logic [PC_W-1:0]         ras_push_addr_i = '0;
    logic                    ras_pop_i       = 1'b0;
    logic [PC_W-1:0]         addr_o;
    logic [2:0]              src_o;
    logic                    pending_o;
    logic                    ras_empty_o;
    logic                    ras_full_o;
    logic                    ras_underflow_o;

    pc_gen #(
        .PC_W        (PC_W),
        .START_VALUE (START_VALUE),
        .STEP        (STEP),
        .N_REDIR     (N_REDIR),
        .RAS_DEPTH   (RAS_DEPTH),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .stall_i         (stall_i),
        .exc_i           (exc_i),
        .redir_valid_i   (redir_valid_i),
        .redir_addr_i    (redir_addr_i),
        .ras_push_i      (ras_push_i),
        .ras_push_addr_i (ras_push_addr_i),
        .ras_pop_i       (ras_pop_i),
        .addr_o          (addr_o),
        .src_o           (src_o),
        .pending_o       (pending_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o),
        .ras_underflow_o (ras_underflow_o)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [PC_W-1:0] m_pc;
    logic [2:0]      m_src;
    logic            m_pend;
    int              m_pidx;
    logic [PC_W-1:0] m_paddr;
    logic            m_uf;
    logic [PC_W-1:0] m_ras[$];

    logic [EXP_W-1:0] exp_q[$];

    function automatic logic [EXP_W-1:0] pack(input logic [PC_W-1:0] a, input logic [2:0] s,
                                              input logic p, input logic e, input logic f,
                                              input logic u);
        return {a, s, p, e, f, u};
    endfunction

    function automatic logic [EXP_W-1:0] model_view();
        return pack(m_pc, m_src, m_pend, m_ras.size() == 0, m_ras.size() == RAS_DEPTH, m_uf);
    endfunction

    task automatic model_reset();
        m_pc    = START_VALUE;
        m_src   = SRC_RESET;
        m_pend  = 1'b0;
        m_pidx  = 0;
        m_paddr = '0;
        m_uf    = 1'b0;
        m_ras.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic st, input logic ex,
                         input logic [N_REDIR-1:0] rv, input logic [PC_W-1:0] a0,
                         input logic [PC_W-1:0] a1, input logic push,
                         input logic [PC_W-1:0] pa, input logic pop);
        int              best;
        logic [PC_W-1:0] tgt;
        @(negedge clk_i);
        enable_i        = en;
        stall_i         = st;
        exc_i           = ex;
        redir_valid_i   = rv;
        redir_addr_i    = {a1, a0};
        ras_push_i      = push;
        ras_push_addr_i = pa;
        ras_pop_i       = pop;

        best = -1;
        for (int k = N_REDIR - 1; k >= 0; k--) if (rv[k]) best = k;
        tgt = (best == 1) ? a1 : a0;
        tgt = tgt - (tgt % STEP);

        m_uf = 1'b0;
        if (en) begin
            if (ex) begin
                m_pc   = EXC_VECTOR;
                m_src  = SRC_EXC;
                m_pend = 1'b0;
            end else if (st) begin
                if (best >= 0 && (!m_pend || best <= m_pidx)) begin
                    m_pend  = 1'b1;
                    m_pidx  = best;
                    m_paddr = tgt;
                end
            end else begin
                if (best >= 0 && (!m_pend || best <= m_pidx)) begin
                    m_pc  = tgt;
                    m_src = SRC_REDIR;
                end else if (m_pend) begin
                    m_pc  = m_paddr;
                    m_src = SRC_PEND;
                end else if (pop && m_ras.size() != 0) begin
                    m_pc  = m_ras[m_ras.size()-1];
                    m_src = SRC_RAS;
                    if (push) m_ras[m_ras.size()-1] = pa;
                    else void'(m_ras.pop_back());
                end else begin
                    m_uf  = pop;
                    m_pc  = m_pc + STEP;
                    m_src = SRC_SEQ;
                    if (push) begin
                        m_ras.push_back(pa);
                        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                    end
                end
                m_pend = 1'b0;
            end
        end
        exp_q.push_back(model_view());
    endtask

    task automatic adv();
        drive(1, 0, 0, '0, '0, '0, 0, '0, 0);
    endtask

    task automatic push_op(input logic [PC_W-1:0] pa);
        drive(1, 0, 0, '0, '0, '0, 1, pa, 0);
    endtask

    task automatic pop_op();
        drive(1, 0, 0, '0, '0, '0, 0, '0, 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EXP_W-1:0] mon_exp, mon_act;
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = pack(addr_o, src_o, pending_o, ras_empty_o, ras_full_o, ras_underflow_o);
            tests++;
            if (mon_act !== mon_exp) begin
                fails++;
                $display("FAIL scoreboard #%0d: got addr=%h src=%0d pend=%b empty=%b full=%b uf=%b, expected addr=%h src=%0d pend=%b empty=%b full=%b uf=%b",
                         tests, mon_act[EXP_W-1 -: PC_W], mon_act[6:4], mon_act[3], mon_act[2],
                         mon_act[1], mon_act[0], mon_exp[EXP_W-1 -: PC_W], mon_exp[6:4],
                         mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    // Let the last driven cycle be compared, then idle the inputs.
    task automatic drain();
        @(posedge clk_i);
        #2;
        enable_i      = 1'b0;
        exc_i         = 1'b0;
        redir_valid_i = '0;
        ras_push_i    = 1'b0;
        ras_pop_i     = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk_i);
        reset_i         = 1'b0;
        enable_i        = 1'b0;
        stall_i         = 1'b0;
        exc_i           = 1'b0;
        redir_valid_i   = '0;
        redir_addr_i    = '0;
        ras_push_i      = 1'b0;
        ras_push_addr_i = '0;
        ras_pop_i       = 1'b0;
        #1;
        model_reset();
        check("reset addr", addr_o, START_VALUE);
        check("reset src", 32'(src_o), 32'(SRC_RESET));
        check("reset pending", 32'(pending_o), 32'd0);
        check("reset empty", 32'(ras_empty_o), 32'd1);
        check("reset full", 32'(ras_full_o), 32'd0);
        check("reset underflow", 32'(ras_underflow_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // sequential fetch
        repeat (5) adv();
        drain();
        check("seq addr", addr_o, 32'd20);
        check("seq src", 32'(src_o), 32'(SRC_SEQ));

        // two channels same cycle: ch0 wins
        drive(1, 0, 0, 2'b11, 32'h100, 32'h200, 0, '0, 0);
        drain();
        check("redir prio", addr_o, 32'h100);
        adv();
        drain();
        check("after redir", addr_o, 32'h104);

        // stall: ch1 then ch0 overwrites pending
        drive(1, 1, 0, 2'b10, '0, 32'h200, 0, '0, 0);
        drive(1, 1, 0, 2'b01, 32'h300, '0, 0, '0, 0);
        drain();
        check("pending held", 32'(pending_o), 32'd1);
        check("stall holds pc", addr_o, 32'h104);
        adv();
        drain();
        check("pending consumed", addr_o, 32'h300);
        check("pending cleared", 32'(pending_o), 32'd0);

        // lower priority does not overwrite pending
        drive(1, 1, 0, 2'b01, 32'h500, '0, 0, '0, 0);
        drive(1, 1, 0, 2'b10, '0, 32'h600, 0, '0, 0);
        adv();
        drain();
        check("pending kept", addr_o, 32'h500);

        // live higher priority beats held lower one
        drive(1, 1, 0, 2'b10, '0, 32'h700, 0, '0, 0);
        drive(1, 0, 0, 2'b01, 32'h800, '0, 0, '0, 0);
        drain();
        check("live beats pending", addr_o, 32'h800);

        // exception during stall discards pending
        drive(1, 1, 0, 2'b01, 32'h400, '0, 0, '0, 0);
        drive(1, 1, 1, '0, '0, '0, 0, '0, 0);
        drain();
        check("exc addr", addr_o, EXC_VECTOR);
        check("exc clears pending", 32'(pending_o), 32'd0);

        // alignment and wrap
        drive(1, 0, 0, 2'b10, '0, 32'h10B, 0, '0, 0);
        drain();
        check("aligned target", addr_o, 32'h108);
        drive(1, 0, 0, 2'b01, 32'hFFFF_FFFE, '0, 0, '0, 0);
        adv();
        drain();
        check("wrap", addr_o, 32'h0);

        // disabled: everything ignored
        drive(0, 0, 1, 2'b11, 32'h40, 32'h50, 1, 32'h60, 1);
        drain();
        check("disabled hold", addr_o, 32'h0);

        // RAS push/pop/underflow
        do_reset();
        push_op(32'h10);
        push_op(32'h20);
        pop_op();
        drain();
        check("ras pop1", addr_o, 32'h20);
        pop_op();
        drain();
        check("ras pop2", addr_o, 32'h10);
        pop_op();
        drain();
        check("underflow seq", addr_o, 32'h14);
        check("underflow pulse", 32'(ras_underflow_o), 32'd1);
        check("ras empty", 32'(ras_empty_o), 32'd1);

        // RAS overflow: oldest overwritten
        do_reset();
        for (int k = 1; k <= 8; k++) push_op(32'h1000 + 32'(k) * 32'h10);
        drain();
        check("ras full", 32'(ras_full_o), 32'd1);
        push_op(32'h1090);
        pop_op();
        drain();
        check("ovf first pop", addr_o, 32'h1090);
        repeat (7) pop_op();
        drain();
        check("ovf last pop", addr_o, 32'h1020);
        check("ovf empty", 32'(ras_empty_o), 32'd1);

        // push+pop same cycle replaces top
        push_op(32'h30);
        drive(1, 0, 0, '0, '0, '0, 1, 32'h40, 1);
        drain();
        check("pushpop pc", addr_o, 32'h30);
        pop_op();
        drain();
        check("pushpop top", addr_o, 32'h40);

        // reset while pending
        drive(1, 1, 0, 2'b01, 32'h900, '0, 0, '0, 0);
        drain();
        check("pending before reset", 32'(pending_o), 32'd1);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 39) == 0,
                  {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
                  $urandom(), $urandom(), $urandom_range(0, 3) == 0, $urandom(),
                  $urandom_range(0, 3) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
